// File: rtl/alu_seq.sv
// Clocked EX-stage ALU: single-cycle logic/arith ops plus iterative unsigned
// multiply (shift-add) and divide (restoring) behind a start/busy/done handshake.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       ctlSignal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] resultHi,
    output logic             zero,
    output logic             divByZero
);

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_MULTU = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_SUB   = 3'b110;
    localparam logic [2:0] OP_SLT   = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result, r_result_hi;
    logic             r_dbz;

    logic             w_accept, w_is_multi, w_last;
    logic [WIDTH-1:0] w_diff, w_sc_lo, w_sc_hi;
    logic             w_ovf, w_slt, w_sc_dbz;
    logic [WIDTH:0]   w_mul_sum, w_mul_acc, w_div_sh, w_div_acc;
    logic [WIDTH-1:0] w_mul_q, w_div_q;
    logic             w_div_ge;

    assign w_accept   = start && (r_state != S_CALC);
    assign w_is_multi = (ctlSignal == OP_MULTU) || ((ctlSignal == OP_DIVU) && (dataB != '0));
    assign w_last     = (r_state == S_CALC) && (r_cnt == CNT_W'(1));

    // Signed less-than that stays correct when A-B overflows.
    assign w_diff = dataA - dataB;
    assign w_ovf  = (dataA[WIDTH-1] != dataB[WIDTH-1]) && (w_diff[WIDTH-1] != dataA[WIDTH-1]);
    assign w_slt  = w_diff[WIDTH-1] ^ w_ovf;

    always_comb begin
        w_sc_lo  = '0;
        w_sc_hi  = '0;
        w_sc_dbz = 1'b0;
        case (ctlSignal)
            OP_AND: w_sc_lo = dataA & dataB;
            OP_OR:  w_sc_lo = dataA | dataB;
            OP_ADD: w_sc_lo = dataA + dataB;
            OP_SUB: w_sc_lo = w_diff;
            OP_SLT: w_sc_lo = {{(WIDTH-1){1'b0}}, w_slt};
            OP_DIVU: begin
                w_sc_lo  = '1;
                w_sc_hi  = dataA;
                w_sc_dbz = 1'b1;
            end
            default: w_sc_lo = '0;
        endcase
    end

    // One iteration step: multiply retires LSB of r_q, divide consumes MSB of r_q.
    assign w_mul_sum = r_acc + (r_q[0] ? {1'b0, r_b} : '0);
    assign w_mul_acc = {1'b0, w_mul_sum[WIDTH:1]};
    assign w_mul_q   = {w_mul_sum[0], r_q[WIDTH-1:1]};

    assign w_div_sh  = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_div_ge  = w_div_sh >= {1'b0, r_b};
    assign w_div_acc = w_div_ge ? (w_div_sh - {1'b0, r_b}) : w_div_sh;
    assign w_div_q   = {r_q[WIDTH-2:0], w_div_ge};

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CALC: if (w_last) w_state_nxt = S_DONE;
            default: begin
                if (w_accept) w_state_nxt = w_is_multi ? S_CALC : S_DONE;
                else          w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_is_div <= (ctlSignal == OP_DIVU);
            r_acc    <= '0;
            r_q      <= dataA;
            r_b      <= dataB;
        end else if (r_state == S_CALC) begin
            r_acc <= r_is_div ? w_div_acc : w_mul_acc;
            r_q   <= r_is_div ? w_div_q : w_mul_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_dbz       <= 1'b0;
        end else if (w_accept) begin
            if (w_is_multi) begin
                r_cnt <= CNT_W'(WIDTH);
            end else begin
                r_result    <= w_sc_lo;
                r_result_hi <= w_sc_hi;
                r_dbz       <= w_sc_dbz;
            end
        end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt - 1'b1;
            if (w_last) begin
                r_result    <= r_is_div ? w_div_q : w_mul_q;
                r_result_hi <= r_is_div ? w_div_acc[WIDTH-1:0] : w_mul_acc[WIDTH-1:0];
                r_dbz       <= 1'b0;
            end
        end
    end

    assign busy      = (r_state == S_CALC);
    assign done      = (r_state == S_DONE);
    assign result    = r_result;
    assign resultHi  = r_result_hi;
    assign zero      = (r_result == '0);
    assign divByZero = r_dbz;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   ctlSignal = '0;
    logic [W-1:0] dataA = '0, dataB = '0;
    logic         busy, done, zero, divByZero;
    logic [W-1:0] result, resultHi;

    int n_chk = 0;
    int n_err = 0;
    logic [W-1:0] last_lo = '0;
    logic [W-1:0] last_hi = '0;

    alu_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .ctlSignal(ctlSignal),
        .dataA(dataA), .dataB(dataB), .busy(busy), .done(done),
        .result(result), .resultHi(resultHi), .zero(zero), .divByZero(divByZero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] lo, output logic [W-1:0] hi,
                         output logic dbz, output int lat);
        logic [63:0] p;
        lo = '0; hi = '0; dbz = 1'b0; lat = 1;
        case (op)
            3'd0: lo = a & b;
            3'd1: lo = a | b;
            3'd2: lo = a + b;
            3'd6: lo = a - b;
            3'd7: lo = ($signed(a) < $signed(b)) ? 1 : 0;
            3'd3: begin
                p = 64'(a) * 64'(b);
                lo = p[W-1:0]; hi = p[2*W-1:W]; lat = W + 1;
            end
            3'd4: begin
                if (b == 0) begin lo = '1; hi = a; dbz = 1'b1; end
                else begin lo = a / b; hi = a % b; lat = W + 1; end
            end
            default: ;
        endcase
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit b2b, input bit poke);
        logic [W-1:0] elo, ehi;
        logic edbz;
        int elat, cyc, bcnt;
        model(op, a, b, elo, ehi, edbz, elat);
        start = 1'b1; ctlSignal = op; dataA = a; dataB = b;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; bcnt = 0;
        while (!done && cyc < W + 8) begin
            if (busy) bcnt++;
            if (cyc == 2) check({tag, "_hold"}, result, last_lo);
            if (poke && cyc == 5) begin start = 1'b1; ctlSignal = 3'd0; end
            else start = 1'b0;
            dataA = $urandom; dataB = $urandom;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check({tag, "_lat"}, cyc, elat);
        check({tag, "_busy"}, bcnt, elat - 1);
        check({tag, "_lo"}, result, elo);
        check({tag, "_hi"}, resultHi, ehi);
        check({tag, "_zero"}, zero, (elo == 0));
        check({tag, "_dbz"}, divByZero, edbz);
        last_lo = elo; last_hi = ehi;
        if (!b2b) begin
            @(posedge clk); #1;
            check({tag, "_pulse"}, done, 1'b0);
        end
    endtask

    initial begin
        logic [2:0] op;
        logic [W-1:0] a, b;
        int pulses;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_lo", result, '0);
        check("rst_hi", resultHi, '0);
        check("rst_zero", zero, 1'b1);
        check("rst_dbz", divByZero, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("add_wrap", 3'd2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        run_op("slt_ovf1", 3'd7, 32'h8000_0000, 32'h1, 1'b0, 1'b0);
        run_op("slt_ovf2", 3'd7, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("sub_neg", 3'd6, 32'd5, 32'd7, 1'b0, 1'b0);
        run_op("mul_big", 3'd3, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);
        run_op("div_100_7", 3'd4, 32'd100, 32'd7, 1'b0, 1'b0);
        run_op("div_zero", 3'd4, 32'd5, 32'd0, 1'b0, 1'b0);
        run_op("rsvd", 3'd5, 32'h1234, 32'h5678, 1'b0, 1'b0);
        run_op("mul_b2b", 3'd3, 32'd3, 32'd4, 1'b1, 1'b0);
        run_op("and_b2b", 3'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 1'b0);

        // Abort a divide partway through with reset.
        start = 1'b1; ctlSignal = 3'd4; dataA = 32'd100; dataB = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_lo", result, '0);
        check("abort_zero", zero, 1'b1);
        pulses = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check("abort_nopulse", pulses, 0);
        last_lo = '0; last_hi = '0;

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: b = W'($urandom_range(1, 15));
                2: a = W'($urandom_range(0, 255));
                default: ;
            endcase
            run_op("rand", op, a, b, bit'($urandom_range(0, 1)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
